seq1101_tx: RTL and testbench

Serial frame transmitter that emits the 1101 sync sequence followed by a parallel payload, one bit per clock. It is the transmit side for the team's 1101 sequence detectors: its serial output feeds a detector's `in` port. A Moore FSM sequences the frame. The block accepts one payload word per frame through a ready/start handshake and ends each frame with a zero-filled gap, so that non-overlapping detection restarts cleanly.

---
 rtl/seq1101_pkg.sv | 29 ++
 rtl/seq1101_tx.sv | 108 ++++++++++
 tb/tb_seq1101_tx.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/seq1101_pkg.sv
// seq1101_pkg: shared definitions for the 1101 sync-frame transmitter.
//   state_t    - frame sequencer states (idle, sync, payload, gap)
//   SYNC_WORD  - sync pattern, transmitted MSB first
//   SYNC_LEN   - number of sync bits
//   cnt_width  - width of the per-state bit down-counter
package seq1101_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_DATA = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    localparam logic [3:0] SYNC_WORD = 4'b1101;
    localparam int         SYNC_LEN  = 4;

    // The counter holds "bits remaining after the current one", so its
    // largest value is max(SYNC_LEN, dw, gp) - 1. Because SYNC_LEN is 4,
    // the result is never less than 2 bits.
    function automatic int cnt_width(input int dw, input int gp);
        int m;
        m = SYNC_LEN;
        if (dw > m) m = dw;
        if (gp > m) m = gp;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/seq1101_tx.sv
// seq1101_tx: serial frame transmitter. Each frame is the sync pattern 1101,
// then DATA_W payload bits (MSB first), then GAP zero bits, one bit per clock.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   start      in   frame request, sampled only while ready=1
//   data       in   payload word, captured on the accepting edge
//   ready      out  high only while idle
//   out        out  registered serial bit stream
//   done       out  one-cycle pulse in the first idle cycle after a frame
//   dbg_state  out  current sequencer state
//
// Handshake: a frame is accepted at a rising edge where ready=1 and start=1.
// start while ready=0 is dropped, not queued. ready is low from the accepting
// edge until the frame's last gap bit has been sent.
module seq1101_tx
    import seq1101_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int GAP    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    output logic              ready,
    output logic              out,
    output logic              done,
    output state_t            dbg_state
);

    localparam int CW = cnt_width(DATA_W, GAP);

    state_t            state;
    logic [CW-1:0]     cnt;    // bits still to send in this state after the current one
    logic [DATA_W-1:0] shreg;  // payload, MSB is the next payload bit

    assign dbg_state = state;

    // Every output is assigned with the state that drives it, so out, ready
    // and done are registered and never combinational from start or data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            shreg <= '0;
            out   <= 1'b0;
            ready <= 1'b1;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    out <= 1'b0;
                    if (start) begin
                        state <= ST_SYNC;
                        ready <= 1'b0;
                        shreg <= data;
                        out   <= SYNC_WORD[SYNC_LEN-1];
                        cnt   <= CW'(SYNC_LEN - 1);
                    end
                end
                ST_SYNC: begin
                    if (cnt != '0) begin
                        // cnt is at most 3 here, so the low two bits index the word.
                        out <= SYNC_WORD[cnt[1:0] - 2'd1];
                        cnt <= cnt - 1'b1;
                    end else begin
                        state <= ST_DATA;
                        out   <= shreg[DATA_W-1];
                        shreg <= shreg << 1;
                        cnt   <= CW'(DATA_W - 1);
                    end
                end
                ST_DATA: begin
                    if (cnt != '0) begin
                        out   <= shreg[DATA_W-1];
                        shreg <= shreg << 1;
                        cnt   <= cnt - 1'b1;
                    end else begin
                        state <= ST_GAP;
                        out   <= 1'b0;
                        cnt   <= CW'(GAP - 1);
                    end
                end
                ST_GAP: begin
                    out <= 1'b0;
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state <= ST_IDLE;
                        ready <= 1'b1;
                        done  <= 1'b1;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    ready <= 1'b1;
                    out   <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq1101_tx.sv
module tb_seq1101_tx;
    import seq1101_pkg::*;

    localparam int DW = 8;
    localparam int GP = 2;
    localparam int FL = 4 + DW + GP;  // frame length in cycles

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] data = '0;
    logic          ready, out, done;
    state_t        dbg_state;

    always #5 clk = ~clk;

    seq1101_tx #(.DATA_W(DW), .GAP(GP)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .data      (data),
        .ready     (ready),
        .out       (out),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [2:0] exp_q[$];     // expected {ready, done, out} per cycle
    int         acc_q[$];     // accept cycles (loopback phase)
    int         det_q[$];     // detector hit cycles (loopback phase)
    int         done_cyc[$];  // observed done pulses (back-to-back phase)
    logic       loop_en    = 1'b0;
    logic       track_done = 1'b0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s @cyc %0d: got=%0h want=%0h", nm, cyc, got, want);
        end
    endtask

    // ---------------- reference model ----------------
    // A frame is a flat list of bits: sync pattern, payload MSB first, zeros.
    function automatic logic frame_bit(input logic [DW-1:0] d, input int p);
        logic [3:0] s;
        s = 4'b1101;
        if (p < 4) return s[3-p];
        if (p < 4 + DW) return d[DW-1-(p-4)];
        return 1'b0;
    endfunction

    int            pos = -1;   // -1 idle, 0..FL-1 frame bit, FL done cycle
    logic [DW-1:0] fdata;
    logic [3:0]    hist;
    int            n_hist = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos = -1;
            exp_q.delete();
            n_hist = 0;
        end else begin
            cyc++;
            // Bench-side non-overlapping 1101 detector on the line
            if (loop_en) begin
                hist = {hist[2:0], out};
                if (n_hist < 4) n_hist++;
                if (n_hist == 4 && hist == 4'b1101) begin
                    det_q.push_back(cyc);
                    n_hist = 0;
                end
            end
            // Frame position model
            if ((pos < 0 || pos == FL) && start) begin
                fdata = data;
                pos   = 0;
                if (loop_en) acc_q.push_back(cyc);
            end else if (pos >= 0 && pos < FL) begin
                pos++;
            end else begin
                pos = -1;
            end
            if (pos < 0)        exp_q.push_back(3'b100);
            else if (pos == FL) exp_q.push_back(3'b110);
            else                exp_q.push_back({2'b00, frame_bit(fdata, pos)});
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [2:0] e;
        if (!rst) begin
            check("reset_rdy_done_out", {29'd0, ready, done, out}, 32'b100);
            check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
        end else if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty @cyc %0d: got=no_expectation want=one_entry", cyc);
        end else begin
            e = exp_q.pop_front();
            check("stream_rdy_done_out", {29'd0, ready, done, out}, {29'd0, e});
            if (track_done && done) done_cyc.push_back(cyc);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_frame(input logic [DW-1:0] d, input int busy_at,
                             input logic [FL-1:0] want, input string nm);
        logic [FL-1:0] cap;
        cap = '0;
        @(negedge clk);
        start = 1'b1;
        data  = d;
        for (int i = 0; i < FL; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            if (i == busy_at) begin
                start = 1'b1;
                data  = 8'hFF;
            end
            if (i == busy_at + 1) start = 1'b0;
            cap = {cap[FL-2:0], out};
        end
        @(negedge clk);
        check(nm, 32'(cap), 32'(want));
        check({nm, "_done"}, 32'(done), 32'd1);
        check({nm, "_ready"}, 32'(ready), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset held for 2 cycles, released away from the edge
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        repeat (10) @(negedge clk);

        // Single frame, A5
        run_frame(8'hA5, -1, 14'b11011010010100, "frame_A5");
        repeat (3) @(negedge clk);

        // Busy rejection: start with FF mid-frame must be ignored
        run_frame(8'hA5, 6, 14'b11011010010100, "frame_busy");
        repeat (FL + 3) @(negedge clk);
        check("busy_no_second_frame", 32'(ready), 32'd1);

        // Back-to-back with start held high
        track_done = 1'b1;
        done_cyc.delete();
        @(negedge clk);
        start = 1'b1;
        data  = 8'h3C;
        @(negedge clk);
        data  = 8'hC3;
        repeat (19) @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        track_done = 1'b0;
        check("b2b_done_count", 32'(done_cyc.size()), 32'd2);
        if (done_cyc.size() == 2)
            check("b2b_done_spacing", 32'(done_cyc[1] - done_cyc[0]), 32'(FL + 1));

        // Reset during payload bit 3 (payload all ones so out is 1 there)
        @(negedge clk);
        start = 1'b1;
        data  = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        check("pre_reset_out", 32'(out), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("async_reset_out", 32'(out), 32'd0);
        check("async_reset_ready", 32'(ready), 32'd1);
        check("async_reset_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        run_frame(8'h81, -1, 14'b11011000000100, "frame_81_after_reset");
        repeat (2) @(negedge clk);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            data  = DW'($urandom_range(0, 255));
        end
        @(negedge clk);
        start = 1'b0;
        repeat (FL + 3) @(negedge clk);

        // Loopback into the detector: 5 frames of 00
        acc_q.delete();
        det_q.delete();
        loop_en = 1'b1;
        for (int f = 0; f < 5; f++) begin
            @(negedge clk);
            start = 1'b1;
            data  = 8'h00;
            @(negedge clk);
            start = 1'b0;
            repeat (FL + 1) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        loop_en = 1'b0;
        check("loop_accepts", 32'(acc_q.size()), 32'd5);
        check("loop_detections", 32'(det_q.size()), 32'd5);
        if (det_q.size() == acc_q.size()) begin
            for (int i = 0; i < det_q.size(); i++)
                check("loop_det_cycle", 32'(det_q[i]), 32'(acc_q[i] + 4));
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
